// File: rtl/synth_pkg.sv
// synth_pkg: shared constants for the voice allocator slice.
// FSM encodings, default sizes and the voice code slice helper.
`ifndef VOICE_CODE_SLICE
`define VOICE_CODE_SLICE(i, w) (i)*(w) +: (w)
`endif

package synth_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SCAN   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_SCAN   = SCAN,
    ST_COMMIT = COMMIT
  } state_t;

  localparam int NUM_VOICES_D = 8;
  localparam int CODE_W_D     = 8;
  localparam int AGE_W_D      = 4;

endpackage

// File: rtl/voice_slot.sv
// voice_slot: gate, hold, key code and age of one synth voice.
// Allocator commands take priority over the pedal release.
module voice_slot
  import synth_pkg::*;
#(
  parameter int CODE_W = CODE_W_D,
  parameter int AGE_W  = AGE_W_D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc,
  input  logic              retrig,
  input  logic              rel,
  input  logic              hold,
  input  logic              clear_held,
  input  logic              age_inc,
  input  logic [CODE_W-1:0] new_code,
  output logic              gate,
  output logic [CODE_W-1:0] code,
  output logic [AGE_W-1:0]  age
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic held;

  // One command per cycle; otherwise pedal release and ageing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gate <= 1'b0;
      held <= 1'b0;
      code <= '0;
      age  <= '0;
    end else if (alloc) begin
      gate <= 1'b1;
      held <= 1'b0;
      code <= new_code;
      age  <= '0;
    end else if (retrig) begin
      gate <= 1'b1;
      held <= 1'b0;
      age  <= '0;
    end else if (rel) begin
      gate <= 1'b0;
      held <= 1'b0;
    end else if (hold) begin
      held <= 1'b1;
    end else begin
      if (clear_held && held) begin
        gate <= 1'b0;
        held <= 1'b0;
      end
      if (age_inc && gate && age != AGE_MAX) begin
        age <= age + 1'b1;
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: shares NUM_VOICES oscillators between key events.
// Scans slots one per cycle, then retriggers, allocates or steals.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_D,
  parameter int CODE_W     = CODE_W_D,
  parameter int AGE_W      = AGE_W_D
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         key_valid,
  output logic                         key_ready,
  input  logic [CODE_W-1:0]            key_code,
  input  logic                         key_make,
  input  logic                         sustain,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NUM_VOICES*CODE_W-1:0] voice_code,
  output logic [NUM_VOICES-1:0]        voice_start,
  output logic                         steal,
  output logic                         busy
);

  localparam int SLOT_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int IDX_W  = $clog2(NUM_VOICES + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VOICES);

  state_t state;

  logic [IDX_W-1:0]  idx;
  logic [CODE_W-1:0] ev_code;
  logic              ev_make;

  logic              p_vld;
  logic [SLOT_W-1:0] p_idx;
  logic              p_gate;
  logic [CODE_W-1:0] p_code;
  logic [AGE_W-1:0]  p_age;

  logic              m_hit;
  logic [SLOT_W-1:0] m_idx;
  logic              f_hit;
  logic [SLOT_W-1:0] f_idx;
  logic              o_hit;
  logic [SLOT_W-1:0] o_idx;
  logic [AGE_W-1:0]  o_age;

  logic              rd_gate;
  logic [CODE_W-1:0] rd_code;
  logic [AGE_W-1:0]  rd_age;

  logic              sus_q;
  logic              sus_qq;
  logic              fall;

  logic              commit;
  logic              press;
  logic              brk;
  logic              take;
  logic [SLOT_W-1:0] tgt;

  logic [NUM_VOICES-1:0] alloc;
  logic [NUM_VOICES-1:0] retrig;
  logic [NUM_VOICES-1:0] rel;
  logic [NUM_VOICES-1:0] hold;
  logic [NUM_VOICES-1:0] start_d;
  logic                  steal_d;

  logic [NUM_VOICES-1:0] slot_gate;
  logic [CODE_W-1:0]     slot_code [NUM_VOICES];
  logic [AGE_W-1:0]      slot_age  [NUM_VOICES];

  assign key_ready  = (state == ST_IDLE);
  assign busy       = ~key_ready;
  assign voice_gate = slot_gate;
  assign fall       = sus_qq & ~sus_q;

  // Slot read port addressed by the scan index.
  always_comb begin
    rd_gate = 1'b0;
    rd_code = '0;
    rd_age  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (idx == IDX_W'(i)) begin
        rd_gate = slot_gate[i];
        rd_code = slot_code[i];
        rd_age  = slot_age[i];
      end
    end
  end

  // Event FSM: latch, walk slots through a one-deep read pipe, commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      ev_code <= '0;
      ev_make <= 1'b0;
      p_vld   <= 1'b0;
      p_idx   <= '0;
      p_gate  <= 1'b0;
      p_code  <= '0;
      p_age   <= '0;
      m_hit   <= 1'b0;
      m_idx   <= '0;
      f_hit   <= 1'b0;
      f_idx   <= '0;
      o_hit   <= 1'b0;
      o_idx   <= '0;
      o_age   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (key_valid) begin
            ev_code <= key_code;
            ev_make <= key_make;
            idx     <= '0;
            p_vld   <= 1'b0;
            m_hit   <= 1'b0;
            f_hit   <= 1'b0;
            o_hit   <= 1'b0;
            o_age   <= '0;
            state   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (idx != LAST) begin
            p_vld  <= 1'b1;
            p_idx  <= idx[SLOT_W-1:0];
            p_gate <= rd_gate;
            p_code <= rd_code;
            p_age  <= rd_age;
            idx    <= idx + 1'b1;
          end else begin
            p_vld <= 1'b0;
            state <= ST_COMMIT;
          end
          if (p_vld && p_gate && !m_hit && p_code == ev_code) begin
            m_hit <= 1'b1;
            m_idx <= p_idx;
          end
          if (p_vld && !p_gate && !f_hit) begin
            f_hit <= 1'b1;
            f_idx <= p_idx;
          end
          if (p_vld && p_gate && (!o_hit || p_age > o_age)) begin
            o_hit <= 1'b1;
            o_idx <= p_idx;
            o_age <= p_age;
          end
        end
        ST_COMMIT: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign commit = (state == ST_COMMIT);
  assign press  = commit & ev_make;
  assign brk    = commit & ~ev_make;
  assign take   = press & ~m_hit & (f_hit | o_hit);
  assign tgt    = f_hit ? f_idx : o_idx;

  // Decode the scan result into per-slot commands.
  always_comb begin
    alloc   = '0;
    retrig  = '0;
    rel     = '0;
    hold    = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      retrig[i] = press & m_hit & (m_idx == SLOT_W'(i));
      alloc[i]  = take & (tgt == SLOT_W'(i));
      rel[i]    = brk & m_hit & (m_idx == SLOT_W'(i)) & ~sustain;
      hold[i]   = brk & m_hit & (m_idx == SLOT_W'(i)) & sustain;
    end
    start_d = alloc | retrig;
    steal_d = press & ~m_hit & ~f_hit & o_hit;
  end

  // Pedal history for the falling-edge release of held voices.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sus_q  <= 1'b0;
      sus_qq <= 1'b0;
    end else begin
      sus_q  <= sustain;
      sus_qq <= sus_q;
    end
  end

  // Phase restart and steal pulses, one cycle after COMMIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      voice_start <= '0;
      steal       <= 1'b0;
    end else begin
      voice_start <= start_d;
      steal       <= steal_d;
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    voice_slot #(
      .CODE_W (CODE_W),
      .AGE_W  (AGE_W)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .alloc      (alloc[i]),
      .retrig     (retrig[i]),
      .rel        (rel[i]),
      .hold       (hold[i]),
      .clear_held (fall),
      .age_inc    (press),
      .new_code   (ev_code),
      .gate       (slot_gate[i]),
      .code       (slot_code[i]),
      .age        (slot_age[i])
    );
    assign voice_code[`VOICE_CODE_SLICE(i, CODE_W)] = slot_code[i];
  end

endmodule
